// File: rtl/xor_frame_checksum_if.sv
`default_nettype none
// Beat stream in, per-beat XOR and frame summary out, for xor_frame_checksum.
// The master is the source/sink side; the slave is the checksum block.
interface xor_frame_checksum_if #(
  parameter int NR_OF_INPUTS  = 2,
  parameter int NR_OF_BITS    = 8,
  parameter int MAX_FRAME_LEN = 16
);
  localparam int CW = $clog2(MAX_FRAME_LEN + 1);

  logic [NR_OF_INPUTS*NR_OF_BITS-1:0] in_data;
  logic                               in_valid;
  logic                               in_last;
  logic                               in_ready;
  logic [NR_OF_BITS-1:0]              word_xor;
  logic                               word_valid;
  logic [NR_OF_BITS-1:0]              sum_data;
  logic                               sum_parity;
  logic [CW-1:0]                      sum_count;
  logic                               sum_overflow;
  logic                               sum_valid;
  logic                               sum_ready;

  modport master (
    output in_data, in_valid, in_last, sum_ready,
    input  in_ready, word_xor, word_valid, sum_data, sum_parity,
           sum_count, sum_overflow, sum_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, sum_ready,
    output in_ready, word_xor, word_valid, sum_data, sum_parity,
           sum_count, sum_overflow, sum_valid
  );
endinterface
`default_nettype wire

// File: rtl/xor_frame_checksum.sv
`default_nettype none
// xor_frame_checksum: bubbled XOR across NR_OF_INPUTS words per beat, accumulated
// into a per-frame checksum/parity/count summary delivered over valid/ready.
module xor_frame_checksum #(
  parameter int          NR_OF_INPUTS  = 2,
  parameter int          NR_OF_BITS    = 8,
  parameter logic [64:0] BubblesMask   = 65'd1,
  parameter int          MAX_FRAME_LEN = 16
) (
  input wire logic            clock,
  input wire logic            reset,
  xor_frame_checksum_if.slave bus
);
  localparam int CW = $clog2(MAX_FRAME_LEN + 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                state_q;
  logic                  in_ready_q;
  logic                  word_valid_q;
  logic [NR_OF_BITS-1:0] word_xor_q;
  logic [NR_OF_BITS-1:0] acc_q;
  logic [CW-1:0]         count_q;
  logic [NR_OF_BITS-1:0] sum_data_q;
  logic                  sum_parity_q;
  logic [CW-1:0]         sum_count_q;
  logic                  sum_overflow_q;
  logic                  sum_valid_q;

  logic [NR_OF_BITS-1:0] beat_xor;
  logic [NR_OF_BITS-1:0] acc_d;
  logic [CW-1:0]         count_d;
  logic                  accept;
  logic                  close;

  // Only mask bits below NR_OF_INPUTS are ever consulted.
  always_comb begin
    beat_xor = '0;
    for (int i = 0; i < NR_OF_INPUTS; i++) begin
      beat_xor = beat_xor ^ bus.in_data[i*NR_OF_BITS +: NR_OF_BITS]
                          ^ {NR_OF_BITS{BubblesMask[i]}};
    end
  end

  assign acc_d   = acc_q ^ beat_xor;
  assign count_d = count_q + CW'(1);
  assign accept  = bus.in_valid & in_ready_q;
  assign close   = accept & (bus.in_last | (count_d == CW'(MAX_FRAME_LEN)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ACCUM;
      in_ready_q     <= 1'b0;
      word_valid_q   <= 1'b0;
      word_xor_q     <= '0;
      acc_q          <= '0;
      count_q        <= '0;
      sum_data_q     <= '0;
      sum_parity_q   <= 1'b0;
      sum_count_q    <= '0;
      sum_overflow_q <= 1'b0;
      sum_valid_q    <= 1'b0;
    end else begin
      word_valid_q <= accept;
      if (accept) begin
        word_xor_q <= beat_xor;
      end

      if (state_q == ACCUM) begin
        in_ready_q <= 1'b1;
        if (close) begin
          sum_data_q     <= acc_d;
          sum_parity_q   <= ^acc_d;
          sum_count_q    <= count_d;
          sum_overflow_q <= ~bus.in_last;
          sum_valid_q    <= 1'b1;
          acc_q          <= '0;
          count_q        <= '0;
          in_ready_q     <= 1'b0;
          state_q        <= HOLD;
        end else if (accept) begin
          acc_q   <= acc_d;
          count_q <= count_d;
        end
      end else begin
        // in_ready stays low through the release edge, giving one bubble cycle.
        in_ready_q <= 1'b0;
        if (bus.sum_ready) begin
          sum_valid_q <= 1'b0;
          state_q     <= ACCUM;
        end
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.word_xor     = word_xor_q;
  assign bus.word_valid   = word_valid_q;
  assign bus.sum_data     = sum_data_q;
  assign bus.sum_parity   = sum_parity_q;
  assign bus.sum_count    = sum_count_q;
  assign bus.sum_overflow = sum_overflow_q;
  assign bus.sum_valid    = sum_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_xor_frame_checksum.sv
`default_nettype none
// Bench for xor_frame_checksum: table vectors, directed corner sequences and random
// frames scored against a queue-based frame model.
module tb_xor_frame_checksum;
  localparam int          NI   = 3;
  localparam int          NB   = 8;
  localparam int          MFL  = 4;
  localparam int          CW   = $clog2(MFL + 1);
  localparam logic [64:0] MASK = 65'h22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xor_frame_checksum_if #(.NR_OF_INPUTS(NI), .NR_OF_BITS(NB), .MAX_FRAME_LEN(MFL)) bus ();

  xor_frame_checksum #(
    .NR_OF_INPUTS(NI), .NR_OF_BITS(NB), .BubblesMask(MASK), .MAX_FRAME_LEN(MFL)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [NB-1:0] data;
    logic [CW-1:0] count;
    logic          ovf;
  } sum_t;

  typedef struct packed {
    logic [NI*NB-1:0] d;
    logic [NB-1:0]    exp;
    logic             par;
  } vec_t;

  int            total = 0;
  int            bad   = 0;
  logic [NB-1:0] exp_word_q[$];
  logic [NB-1:0] frame_q[$];
  sum_t          exp_sum_q[$];
  int            word_pulses = 0;
  bit            last_sv = 1'b0;
  bit            rand_sink = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name, input int cycles);
    total++;
    bad++;
    $display("FAIL %s: no response after %0d cycles", name, cycles);
  endtask

  function automatic logic [NB-1:0] beat_ref(input logic [NI*NB-1:0] d);
    logic [NB-1:0] r = '0;
    for (int i = 0; i < NI; i++) r ^= MASK[i] ? ~d[i*NB +: NB] : d[i*NB +: NB];
    return r;
  endfunction

  task automatic model_accept(input logic [NI*NB-1:0] d, input logic last);
    logic [NB-1:0] b = beat_ref(d);
    logic [NB-1:0] s = '0;
    exp_word_q.push_back(b);
    frame_q.push_back(b);
    if (last || frame_q.size() == MFL) begin
      foreach (frame_q[k]) s ^= frame_q[k];
      exp_sum_q.push_back(sum_t'{data: s, count: CW'(frame_q.size()), ovf: !last});
      frame_q.delete();
    end
  endtask

  task automatic send_beat(input logic [NI*NB-1:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      fail_timeout("in_ready_wait", n);
      bus.in_valid = 1'b0;
    end else begin
      model_accept(d, last);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b1;
      bus.in_data  = NI*NB'($urandom);
    end
    @(negedge clk);
    bus.in_last = 1'b0;
  endtask

  // Expects sum_valid already visible (or within a short bound), checks it, then takes it.
  task automatic expect_sum(input string tag, input logic [NB-1:0] d, input int cnt, input logic ovf);
    int n = 0;
    while (!bus.sum_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      fail_timeout({tag, ".sum_valid"}, n);
    end else begin
      check({tag, ".latency"}, n, 0);
      check({tag, ".sum_data"}, bus.sum_data, d);
      check({tag, ".sum_count"}, bus.sum_count, cnt);
      check({tag, ".sum_overflow"}, bus.sum_overflow, ovf);
      check({tag, ".sum_parity"}, bus.sum_parity, ^d);
      #1 bus.sum_ready = 1'b1;
      @(posedge clk);
      #1 bus.sum_ready = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, bus.in_ready, 0);
    check({tag, ".word_xor"}, bus.word_xor, 0);
    check({tag, ".word_valid"}, bus.word_valid, 0);
    check({tag, ".sum_data"}, bus.sum_data, 0);
    check({tag, ".sum_parity"}, bus.sum_parity, 0);
    check({tag, ".sum_count"}, bus.sum_count, 0);
    check({tag, ".sum_overflow"}, bus.sum_overflow, 0);
    check({tag, ".sum_valid"}, bus.sum_valid, 0);
  endtask

  // Scoreboard: word pulses against the word queue; a summary is retired when sum_valid falls.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      last_sv = 1'b0;
    end else begin
      if (bus.word_valid) begin
        word_pulses++;
        check("mon.word_valid", bus.word_valid, 32'(exp_word_q.size() != 0));
        if (exp_word_q.size() != 0) check("mon.word_xor", bus.word_xor, exp_word_q.pop_front());
      end
      if (bus.sum_valid) begin
        check("mon.sum_valid", bus.sum_valid, 32'(exp_sum_q.size() != 0));
        if (exp_sum_q.size() != 0) begin
          check("mon.sum_data", bus.sum_data, exp_sum_q[0].data);
          check("mon.sum_count", bus.sum_count, exp_sum_q[0].count);
          check("mon.sum_overflow", bus.sum_overflow, exp_sum_q[0].ovf);
          check("mon.sum_parity", bus.sum_parity, ^exp_sum_q[0].data);
        end
      end else if (last_sv && exp_sum_q.size() != 0) begin
        void'(exp_sum_q.pop_front());
      end
      last_sv = bus.sum_valid;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_sink) bus.sum_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  int   pulses0;
  int   n;

  initial begin
    vecs[0] = '{d: 24'hF0_00_0F, exp: 8'h00, par: 1'b0};
    vecs[1] = '{d: 24'h00_FF_00, exp: 8'h00, par: 1'b0};
    vecs[2] = '{d: 24'h00_00_00, exp: 8'hFF, par: 1'b0};
    vecs[3] = '{d: 24'h00_00_AA, exp: 8'h55, par: 1'b0};
    vecs[4] = '{d: 24'h01_FF_00, exp: 8'h01, par: 1'b1};
    vecs[5] = '{d: 24'h12_34_56, exp: 8'h8F, par: 1'b1};

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.sum_ready = 1'b0;

    #1 check_all_zero("reset");
    @(negedge clk);
    check("reset.in_ready_held", bus.in_ready, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_reset.in_ready", bus.in_ready, 1);

    // Single-beat frames from the table.
    for (int i = 0; i < 6; i++) begin
      send_beat(vecs[i].d, 1'b1);
      check($sformatf("vec%0d.word_valid", i), bus.word_valid, 1);
      check($sformatf("vec%0d.word_xor", i), bus.word_xor, vecs[i].exp);
      check($sformatf("vec%0d.parity", i), bus.sum_parity, vecs[i].par);
      expect_sum($sformatf("vec%0d", i), vecs[i].exp, 1, 1'b0);
    end

    // Three-beat frame, then backpressure on its summary.
    send_beat(24'h00_FF_12, 1'b0);
    send_beat(24'h00_FF_34, 1'b0);
    send_beat(24'h00_FF_56, 1'b1);
    check("three.sum_valid", bus.sum_valid, 1);
    check("three.sum_data", bus.sum_data, 8'h70);
    check("three.sum_parity", bus.sum_parity, 1);
    check("three.sum_count", bus.sum_count, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.in_ready", bus.in_ready, 0);
      check("bp.sum_valid", bus.sum_valid, 1);
      check("bp.sum_data", bus.sum_data, 8'h70);
    end
    #1 bus.sum_ready = 1'b1;
    @(posedge clk);
    #1 bus.sum_ready = 1'b0;
    @(negedge clk);
    check("bp.sum_valid_drop", bus.sum_valid, 0);
    check("bp.bubble", bus.in_ready, 0);
    @(negedge clk);
    check("bp.in_ready_back", bus.in_ready, 1);

    // Overflow: six beats with in_last only on the sixth.
    send_beat(24'h00_FF_01, 1'b0);
    send_beat(24'h00_FF_02, 1'b0);
    send_beat(24'h00_FF_04, 1'b0);
    send_beat(24'h00_FF_08, 1'b0);
    expect_sum("ovf1", 8'h0F, 4, 1'b1);
    send_beat(24'h00_FF_10, 1'b0);
    send_beat(24'h00_FF_20, 1'b1);
    expect_sum("ovf2", 8'h30, 2, 1'b0);

    // Reset in the middle of a frame discards it.
    send_beat(24'h00_FF_11, 1'b0);
    send_beat(24'h00_FF_22, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    exp_word_q.delete();
    frame_q.delete();
    exp_sum_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    send_beat(24'h00_FF_AA, 1'b1);
    expect_sum("after_reset", 8'hAA, 1, 1'b0);

    // Idle gaps with stray in_last while in_valid is low.
    pulses0 = word_pulses;
    send_beat(24'h00_FF_3C, 1'b0);
    idle(2);
    send_beat(24'h00_FF_C5, 1'b1);
    expect_sum("gaps", 8'hF9, 2, 1'b0);
    @(negedge clk);
    check("gaps.word_pulses", word_pulses - pulses0, 2);

    // Random frames against the model with a random sink.
    rand_sink = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      send_beat(NI*NB'($urandom), $urandom_range(0, 3) == 0);
    end
    if (frame_q.size() != 0) send_beat(NI*NB'($urandom), 1'b1);
    @(negedge clk);
    rand_sink = 1'b0;
    #1 bus.sum_ready = 1'b1;
    n = 0;
    while ((exp_sum_q.size() != 0 || exp_word_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_timeout("drain", n);
    check("drain.sum_left", exp_sum_q.size(), 0);
    check("drain.word_left", exp_word_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
